// File: rtl/miller_rabin_engine.sv
// Purpose: Miller-Rabin probable-prime tester built on a bit-serial modular multiplier.
// Latency: one multiply takes NUM_BITS+1 cycles; each round needs about 2*log2(n) multiplies.
// Backpressure: witnesses are taken only in GET_WIT; the result is held until res_ready.
module miller_rabin_engine #(
    parameter int NUM_BITS = 128,
    parameter int ROUNDS   = 10
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cand_valid,
    output logic                          cand_ready,
    input  logic [NUM_BITS-1:0]           cand_data,
    input  logic                          wit_valid,
    output logic                          wit_ready,
    input  logic [NUM_BITS-1:0]           wit_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_prime,
    output logic [NUM_BITS-1:0]           res_value,
    output logic                          busy,
    output logic [$clog2(ROUNDS+1)-1:0]   rounds_done
);
    localparam int RW = $clog2(ROUNDS+1);
    localparam int SW = $clog2(NUM_BITS+1);
    localparam int BW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam int MW = NUM_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIVIAL, S_DECOMP, S_GET_WIT, S_EXP, S_CHECK, S_SQUARE, S_RESULT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Candidate and decomposition n-1 = d * 2^s
    logic [NUM_BITS-1:0] r_n;
    logic [NUM_BITS-1:0] r_d;
    logic [SW-1:0]       r_s;
    logic [SW-1:0]       r_j;
    logic [RW-1:0]       r_rounds;
    logic                r_prime;

    // Exponentiation state: base, accumulator, remaining exponent bits, pending op
    logic [NUM_BITS-1:0] r_a;
    logic [NUM_BITS-1:0] r_x;
    logic [BW-1:0]       r_bit;
    logic                r_exp_sq;

    // Multiplier state
    logic                r_mul_act;
    logic                r_mul_done;
    logic [BW-1:0]       r_mul_cnt;
    logic [NUM_BITS-1:0] r_mul_a;
    logic [NUM_BITS-1:0] r_mul_b;
    logic [MW-1:0]       r_mul_r;

    logic                w_mul_start;
    logic [NUM_BITS-1:0] w_mul_opb;
    logic [MW-1:0]       w_n_ext;
    logic [MW-1:0]       w_mul_t0;
    logic [MW-1:0]       w_mul_t1;
    logic [MW-1:0]       w_mul_t2;
    logic [NUM_BITS-1:0] w_mul_res;

    logic [NUM_BITS-1:0] w_n_m1;
    logic [NUM_BITS-1:0] w_n_m2;
    logic                w_trivial;
    logic                w_wit_ok;
    logic [NUM_BITS-1:0] w_wit_a;
    logic [BW-1:0]       w_msb;
    logic                w_pass;
    logic                w_fail;
    logic                w_last_round;

    assign w_n_m1       = r_n - NUM_BITS'(1);
    assign w_n_m2       = r_n - NUM_BITS'(2);
    // n < 4 and even n are settled without any witness
    assign w_trivial    = (r_n < NUM_BITS'(4)) || !r_n[0];
    assign w_wit_ok     = (wit_data >= NUM_BITS'(2)) && (wit_data <= w_n_m2);
    assign w_wit_a      = w_wit_ok ? wit_data : NUM_BITS'(2);
    assign w_last_round = (r_rounds == RW'(ROUNDS - 1));

    // One shift-add step: 2r + (bit ? A : 0) stays below 3n, so two trial subtractions suffice
    assign w_n_ext   = {2'b00, r_n};
    assign w_mul_t0  = (r_mul_r << 1) + (r_mul_b[NUM_BITS-1] ? {2'b00, r_mul_a} : '0);
    assign w_mul_t1  = (w_mul_t0 >= w_n_ext) ? (w_mul_t0 - w_n_ext) : w_mul_t0;
    assign w_mul_t2  = (w_mul_t1 >= w_n_ext) ? (w_mul_t1 - w_n_ext) : w_mul_t1;
    assign w_mul_res = r_mul_r[NUM_BITS-1:0];

    // Position of the most significant set bit of d; exponentiation starts just below it
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (r_d[i]) w_msb = BW'(i);
        end
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state, multiplier issue, round verdicts and port outputs
    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_mul_opb   = r_x;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        cand_ready  = aresetn && (r_state == S_IDLE);
        wit_ready   = (r_state == S_GET_WIT);
        res_valid   = (r_state == S_RESULT);
        res_prime   = (r_state == S_RESULT) && r_prime;
        res_value   = (r_state == S_RESULT) ? r_n : '0;
        busy        = (r_state != S_IDLE);
        rounds_done = r_rounds;
        case (r_state)
            S_IDLE: begin
                if (cand_valid) w_state_nxt = S_TRIVIAL;
            end
            S_TRIVIAL: begin
                w_state_nxt = w_trivial ? S_RESULT : S_DECOMP;
            end
            S_DECOMP: begin
                if (r_d[0]) w_state_nxt = S_GET_WIT;
            end
            S_GET_WIT: begin
                if (wit_valid) w_state_nxt = S_EXP;
            end
            S_EXP: begin
                if (!r_mul_act && !r_mul_done) begin
                    if (r_bit == '0) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_mul_start = 1'b1;
                        w_mul_opb   = r_exp_sq ? r_x : r_a;
                    end
                end
            end
            S_CHECK: begin
                if (r_x == NUM_BITS'(1) || r_x == w_n_m1) w_pass = 1'b1;
                else if (r_s == SW'(1))                   w_fail = 1'b1;
                else                                      w_state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
                if (!r_mul_act && !r_mul_done) begin
                    w_mul_start = 1'b1;
                end else if (r_mul_done) begin
                    if (w_mul_res == w_n_m1)                w_pass = 1'b1;
                    else if (w_mul_res == NUM_BITS'(1))     w_fail = 1'b1;
                    else if (r_j + SW'(1) == r_s)           w_fail = 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fail) w_state_nxt = S_RESULT;
        if (w_pass) w_state_nxt = w_last_round ? S_RESULT : S_GET_WIT;
    end

    // Candidate, decomposition, exponent walk and round bookkeeping
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_n      <= '0;
            r_d      <= '0;
            r_s      <= '0;
            r_j      <= '0;
            r_rounds <= '0;
            r_prime  <= 1'b0;
            r_a      <= '0;
            r_x      <= '0;
            r_bit    <= '0;
            r_exp_sq <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cand_valid) begin
                        r_n      <= cand_data;
                        r_rounds <= '0;
                        r_prime  <= 1'b0;
                    end
                end
                S_TRIVIAL: begin
                    r_d     <= w_n_m1;
                    r_s     <= '0;
                    r_prime <= (r_n == NUM_BITS'(2)) || (r_n == NUM_BITS'(3));
                end
                S_DECOMP: begin
                    if (!r_d[0]) begin
                        r_d <= r_d >> 1;
                        r_s <= r_s + SW'(1);
                    end
                end
                S_GET_WIT: begin
                    if (wit_valid) begin
                        r_a      <= w_wit_a;
                        r_x      <= w_wit_a;
                        r_bit    <= w_msb;
                        r_exp_sq <= 1'b1;
                    end
                end
                S_EXP: begin
                    // Square for every bit below the MSB, then multiply by a when that bit is set
                    if (r_mul_done) begin
                        r_x <= w_mul_res;
                        if (r_exp_sq && r_d[r_bit - BW'(1)]) begin
                            r_exp_sq <= 1'b0;
                        end else begin
                            r_exp_sq <= 1'b1;
                            r_bit    <= r_bit - BW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    r_j <= SW'(1);
                end
                S_SQUARE: begin
                    if (r_mul_done) begin
                        r_x <= w_mul_res;
                        r_j <= r_j + SW'(1);
                    end
                end
                default: ;
            endcase
            if (w_pass) begin
                r_rounds <= r_rounds + RW'(1);
                r_prime  <= w_last_round;
            end
            if (w_fail) r_prime <= 1'b0;
        end
    end

    // Bit-serial modular multiplier: x * B mod n, one bit of B per cycle, MSB first
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_mul_act  <= 1'b0;
            r_mul_done <= 1'b0;
            r_mul_cnt  <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_r    <= '0;
        end else begin
            r_mul_done <= 1'b0;
            if (w_mul_start) begin
                r_mul_act <= 1'b1;
                r_mul_r   <= '0;
                r_mul_a   <= r_x;
                r_mul_b   <= w_mul_opb;
                r_mul_cnt <= BW'(NUM_BITS - 1);
            end else if (r_mul_act) begin
                r_mul_r <= w_mul_t2;
                r_mul_b <= r_mul_b << 1;
                if (r_mul_cnt == '0) begin
                    r_mul_act  <= 1'b0;
                    r_mul_done <= 1'b1;
                end else begin
                    r_mul_cnt <= r_mul_cnt - BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_miller_rabin_engine.sv
// Purpose: directed checks of miller_rabin_engine at NUM_BITS=16, ROUNDS=3 against a reference model.
// Latency: results are awaited with a bounded cycle budget per candidate.
// Backpressure: exercises witness stalls and a held-off result consumer.
module tb_miller_rabin_engine;
    localparam int NB = 16;
    localparam int RD = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cand_valid = 1'b0;
    logic          cand_ready;
    logic [NB-1:0] cand_data = '0;
    logic          wit_valid = 1'b0;
    logic          wit_ready;
    logic [NB-1:0] wit_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_prime;
    logic [NB-1:0] res_value;
    logic          busy;
    logic [1:0]    rounds_done;

    miller_rabin_engine #(.NUM_BITS(NB), .ROUNDS(RD)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
        .wit_valid(wit_valid), .wit_ready(wit_ready), .wit_data(wit_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_prime(res_prime),
        .res_value(res_value), .busy(busy), .rounds_done(rounds_done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit            prime;
        logic [NB-1:0] value;
        int            rounds;
        int            used;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wit_hs = 0;
    int   wit_rdy_cyc = 0;

    // Count witness handshakes and cycles with wit_ready high
    always @(posedge aclk) begin
        if (aresetn && wit_valid && wit_ready) wit_hs <= wit_hs + 1;
        if (wit_ready) wit_rdy_cyc <= wit_rdy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                               longint unsigned m);
        longint unsigned r = 1;
        longint unsigned x = b % m;
        while (e != 0) begin
            if ((e & 1) != 0) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    // Textbook Miller-Rabin with the engine's witness substitution rule
    function automatic exp_t mr_model(input longint unsigned n, input longint unsigned ws[3],
                                      input int nw);
        exp_t            e;
        longint unsigned d;
        longint unsigned x;
        longint unsigned a;
        int              s;
        bit              ok;
        e.prime = 0; e.value = n[NB-1:0]; e.rounds = 0; e.used = 0;
        if (n < 2) return e;
        if (n == 2 || n == 3) begin e.prime = 1; return e; end
        if (n % 2 == 0) return e;
        d = n - 1; s = 0;
        while (d % 2 == 0) begin d = d / 2; s++; end
        for (int k = 0; k < nw; k++) begin
            a = ws[k];
            if (a < 2 || a > n - 2) a = 2;
            e.used++;
            x  = powmod(a, d, n);
            ok = (x == 1 || x == n - 1);
            for (int r = 1; r < s && !ok; r++) begin
                x = (x * x) % n;
                if (x == n - 1) ok = 1;
                else if (x == 1) break;
            end
            if (!ok) return e;
            e.rounds++;
            if (e.rounds == RD) begin e.prime = 1; return e; end
        end
        return e;
    endfunction

    task automatic offer_cand(input logic [NB-1:0] n);
        int w = 0;
        @(negedge aclk);
        while (!cand_ready && w < 50) begin @(negedge aclk); w++; end
        cand_valid = 1'b1;
        cand_data  = n;
        @(negedge aclk);
        cand_valid = 1'b0;
        cand_data  = NB'($urandom);
    endtask

    task automatic run_cand(input logic [NB-1:0] n, input logic [NB-1:0] w0,
                            input logic [NB-1:0] w1, input logic [NB-1:0] w2,
                            input int nw, input int max_lat, input int hold, input bit stall);
        longint unsigned ws[3];
        logic [NB-1:0]   wv[3];
        exp_t            e;
        exp_t            g;
        int              base;
        int              rb;
        int              k;
        int              lat;
        bit              got;
        bit              bad;
        wv[0] = w0; wv[1] = w1; wv[2] = w2;
        for (int i = 0; i < 3; i++) ws[i] = longint'(wv[i]);
        e = mr_model(longint'(n), ws, nw);
        sb.push_back(e);
        base = wit_hs;
        rb   = wit_rdy_cyc;
        offer_cand(n);
        lat = 1; got = 0;
        while (!got && lat < 5000) begin
            if (res_valid) begin
                got = 1;
            end else begin
                k         = wit_hs - base;
                wit_valid = (k < nw) && (!stall || (lat % 3) != 0);
                wit_data  = (k < nw) ? wv[k] : NB'($urandom);
                @(negedge aclk);
                lat++;
            end
        end
        wit_valid = 1'b0;
        chk($sformatf("res_seen n=%0d", n), 32'(got), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        g = sb.pop_front();
        chk($sformatf("prime n=%0d", n), 32'(res_prime), 32'(g.prime));
        chk($sformatf("value n=%0d", n), 32'(res_value), 32'(g.value));
        chk($sformatf("rounds n=%0d", n), 32'(rounds_done), 32'(g.rounds));
        chk($sformatf("wits n=%0d", n), 32'(wit_hs - base), 32'(g.used));
        if (max_lat > 0) begin
            chk($sformatf("lat n=%0d", n), 32'(lat <= max_lat), 32'd1);
            chk($sformatf("no_wit_rdy n=%0d", n), 32'(wit_rdy_cyc - rb), 32'd0);
        end
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (res_valid !== 1'b1 || res_prime !== g.prime || res_value !== g.value ||
                    cand_ready !== 1'b0)
                    bad = 1;
            end
            chk($sformatf("hold_stable n=%0d", n), 32'(bad), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge aclk);
        #1 res_ready = 1'b0;
        @(negedge aclk);
        chk($sformatf("res_drop n=%0d", n), 32'(res_valid), 32'd0);
        chk($sformatf("idle n=%0d", n), 32'({cand_ready, busy}), 32'b10);
    endtask

    initial begin
        int base;
        int w;
        // Reset state: every output low while reset is held
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_outputs", 32'({cand_ready, wit_ready, res_valid, res_prime, busy}), 32'd0);
        chk("rst_value", 32'(res_value), 32'd0);
        chk("rst_rounds", 32'(rounds_done), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", 32'(cand_ready), 32'd1);

        // Prime 97, three in-range witnesses
        run_cand(16'd97, 16'd2, 16'd5, 16'd10, 3, 0, 0, 0);
        // Carmichael 561, first witness exposes it
        run_cand(16'd561, 16'd2, 16'd0, 16'd0, 1, 0, 0, 0);
        // Trivial candidates never request a witness
        run_cand(16'd1, 16'd0, 16'd0, 16'd0, 0, 3, 0, 0);
        run_cand(16'd2, 16'd0, 16'd0, 16'd0, 0, 3, 0, 0);
        run_cand(16'd100, 16'd0, 16'd0, 16'd0, 0, 3, 0, 0);
        run_cand(16'd3, 16'd0, 16'd0, 16'd0, 0, 3, 0, 0);
        run_cand(16'd0, 16'd0, 16'd0, 16'd0, 0, 3, 0, 0);
        // Out-of-range witnesses replaced by 2, with witness stalls
        run_cand(16'd13, 16'd0, 16'd12, 16'd1, 3, 0, 0, 1);
        // 25: witness 7 is a strong liar, witness 2 exhausts the squarings
        run_cand(16'd25, 16'd7, 16'd2, 16'd0, 2, 0, 0, 0);
        // Largest 16-bit prime with n-2 (kept) and n-1 (replaced) witnesses
        run_cand(16'd65521, 16'd65519, 16'd3, 16'd65520, 3, 0, 0, 1);
        // Held-off consumer
        run_cand(16'd97, 16'd2, 16'd5, 16'd10, 3, 0, 20, 0);

        // Reset in the middle of exponentiation
        base = wit_hs;
        offer_cand(16'd97);
        wit_valid = 1'b1;
        wit_data  = 16'd2;
        w = 0;
        while (wit_hs == base && w < 100) begin @(negedge aclk); w++; end
        chk("abort_wit_taken", 32'(wit_hs - base), 32'd1);
        repeat (4) @(negedge aclk);
        chk("abort_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("abort_outputs", 32'({cand_ready, wit_ready, res_valid, res_prime, busy}), 32'd0);
        chk("abort_value", 32'(res_value), 32'd0);
        chk("abort_rounds", 32'(rounds_done), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("abort_no_more_wits", 32'(wit_hs - base), 32'd1);
        chk("abort_idle", 32'({cand_ready, busy, res_valid}), 32'b100);
        wit_valid = 1'b0;
        run_cand(16'd7, 16'd3, 16'd3, 16'd3, 3, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/miller_rabin_engine.md
Name: miller_rabin_engine

Overview:
Self-contained, parametrised Miller-Rabin primality tester that replaces the single-shot top and mod_power_m pairing. It accepts a candidate and a stream of witnesses over valid/ready handshakes. All modular arithmetic runs on an internal bit-serial modular multiplier, so no wide combinational multiply or `%` operator is used. It sits between the LFSR random source (candidates and witnesses) and the key-generation consumer.

Parameters:
NUM_BITS, 128, width of candidate, witnesses and all internal arithmetic.
ROUNDS, 10, number of witness rounds that must pass before a candidate is declared prime (≥1).

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, synchronous, active-low; clock aclk.
cand_valid  in  1  candidate offered.
cand_ready  out  1  engine can accept a candidate.
cand_data  in  NUM_BITS  candidate n.
wit_valid  in  1  witness offered.
wit_ready  out  1  engine consumes a witness this cycle when wit_valid is also high.
wit_data  in  NUM_BITS  raw witness w.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_prime  out  1  1 = probable prime, 0 = composite.
res_value  out  NUM_BITS  candidate the result refers to.
busy  out  1  high in every state except IDLE.
rounds_done  out  $clog2(ROUNDS+1)  number of rounds passed for the current candidate.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset mid-operation aborts the test, no result is emitted, and no further witness is consumed.
- FSM states: IDLE, TRIVIAL, DECOMP, GET_WIT, EXP, CHECK, SQUARE, RESULT.
- IDLE:
  - cand_ready=1 only in IDLE.
  - On cand_valid&&cand_ready, latch n and rounds_done=0, then go to TRIVIAL.
- TRIVIAL (1 cycle):
  - n<2 → composite. n==2 or n==3 → prime. n even (>2) → composite. Each of these goes to RESULT.
  - Otherwise go to DECOMP with d=n-1, s=0.
- DECOMP: while d[0]==0, shift d right by one bit and increment s, one bit per cycle. Then go to GET_WIT.
- GET_WIT:
  - wit_ready=1 only here.
  - On handshake, a=w if 2≤w≤n-2, else a=2. Then go to EXP.
- EXP:
  - Compute x=a^d mod n by left-to-right square-and-multiply over the significant bits of d.
  - Each modular multiply is interleaved shift-add: r=2r+(b_i?A:0), followed by up to two conditional subtractions of n, one bit of b per cycle.
  - Internal width is NUM_BITS+2. Each multiply takes NUM_BITS+1 cycles.
- CHECK:
  - If x==1 or x==n-1 the round passes.
  - Else, if s==1, the candidate is composite.
  - Else set j=1 and go to SQUARE.
- SQUARE:
  - x=x*x mod n using the same multiplier.
  - Afterwards: x==n-1 → round passes. x==1 → composite. Else j++; if j==s → composite, otherwise repeat SQUARE.
- Round pass: rounds_done++. If rounds_done reaches ROUNDS → prime and go to RESULT; else return to GET_WIT.
- RESULT:
  - res_valid=1, with res_prime and res_value held stable until res_ready.
  - On res_valid&&res_ready, go to IDLE; res_valid drops next cycle.
  - A new candidate is accepted no earlier than the cycle after the result handshake.
- Witness stall: wit_valid low holds the FSM in GET_WIT indefinitely with no state change.
- Inputs are sampled only on handshake. Changes to cand_data or wit_data at other times are ignored.
- All comparisons are unsigned. n-1 and n-2 are computed at NUM_BITS width, and are never evaluated for n<4 because TRIVIAL catches those cases.

Test Plan:
1. NUM_BITS=16, ROUNDS=3, n=97, witnesses 2,5,10 → exactly 3 witness handshakes, res_prime=1, res_value=97, rounds_done=3.
2. n=561 (Carmichael), witness 2 → internal x=263→166→67→1, res_prime=0 after 1 witness handshake, rounds_done=0.
3. n=1, 2, 100 in sequence → composite, prime, composite; wit_ready never asserted; each result reached within 3 cycles of the candidate handshake.
4. n=13, witnesses 0, 12, 1 (all out of range, so substituted a=2) → res_prime=1 after 3 handshakes.
5. n=97, res_ready held low 20 cycles after res_valid → res_valid, res_prime and res_value stable; cand_ready=0 throughout; release → IDLE next cycle.
6. aresetn pulsed low mid-EXP for n=97 → all outputs 0 the cycle after reset; subsequent n=7 with witness 3 → res_prime=1.
